// File: rtl/ps2_rx_frame_pkg.sv
// ps2_rx_frame shared types and constants.
// Optional mid-frame timeout: define PS2_RX_TIMEOUT_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam logic [3:0] PS2_BITCNT_INIT = 4'hB;
  localparam int PS2_SYNC_STAGES = 2;

  // 1 when data plus parity bit hold an odd number of ones
  function automatic logic ps2_odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Byte output handshake of the PS/2 receiver.
// Master drives the byte, the decoder side is the slave.
interface ps2_rx_frame_if;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  ready,
    output data,
    output valid,
    output parity_err,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output ready,
    input  data,
    input  valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/ps2_rx_frame_clk_filter.sv
// PS/2 line synchronisers, ps2c debounce and fall strobe.
// fall_o pulses one cycle as the filtered clock goes 1->0.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic fall_o,
  output logic sd_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [PS2_SYNC_STAGES-1:0] c_sync_q;
  logic [PS2_SYNC_STAGES-1:0] d_sync_q;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       filt_q, filt_d;
  logic                       fall_q, fall_d;
  logic                       c_s;

  assign c_s    = c_sync_q[PS2_SYNC_STAGES-1];
  assign fall_o = fall_q;
  assign sd_o   = d_sync_q[PS2_SYNC_STAGES-1];

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    fall_d = 1'b0;
    if (c_s != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = c_s;
        fall_d = filt_q & ~c_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      cnt_q    <= '0;
      filt_q   <= 1'b1;
      fall_q   <= 1'b0;
    end else begin
      c_sync_q <= {c_sync_q[PS2_SYNC_STAGES-2:0], ps2c_i};
      d_sync_q <= {d_sync_q[PS2_SYNC_STAGES-2:0], ps2d_i};
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      fall_q   <= fall_d;
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver with valid/ready byte output.
// Optional mid-frame timeout: define PS2_RX_TIMEOUT_EN.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ps2c,
  input  logic     ps2d,
  ps2_rx_frame_if.master rx
);

  ps2_rx_state_t state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       fall, sd, done, hs;
  logic [3:0] idx;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .ps2c_i(ps2c),
    .ps2d_i(ps2d),
    .fall_o(fall),
    .sd_o  (sd)
  );

  assign idx = 4'd10 - bitcnt_q;
  assign hs  = valid_q & rx.ready;

`ifdef PS2_RX_TIMEOUT_EN
  logic [31:0] to_q, to_d;
  logic        to_hit;
  assign to_hit = (state_q != IDLE) && !fall &&
                  (to_q == 32'(TIMEOUT_CYCLES - 1));
  assign to_d = (state_q == IDLE || fall) ? '0 : to_q + 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    done     = 1'b0;
    ferr_d   = 1'b0;
    if (state_q == IDLE) bitcnt_d = PS2_BITCNT_INIT;
    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!sd) begin
            state_d  = DATA;
            bitcnt_d = 4'hA;
          end
        end
        DATA: begin
          shift_d[idx[2:0]] = sd;
          bitcnt_d = bitcnt_q - 1'b1;
          if (bitcnt_q == 4'd3) state_d = PARITY;
        end
        PARITY: begin
          par_d    = sd;
          bitcnt_d = bitcnt_q - 1'b1;
          state_d  = STOP;
        end
        STOP: begin
          bitcnt_d = bitcnt_q - 1'b1;
          state_d  = IDLE;
          done     = sd;
          ferr_d   = ~sd;
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef PS2_RX_TIMEOUT_EN
    if (to_hit) begin
      state_d  = IDLE;
      bitcnt_d = PS2_BITCNT_INIT;
      ferr_d   = 1'b1;
    end
`endif
  end

  always_comb begin
    data_d  = data_q;
    perr_d  = perr_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (hs) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    // Full register with no consumer this cycle keeps the old byte
    if (done) begin
      if (!valid_q || rx.ready) begin
        data_d  = shift_q;
        perr_d  = ~ps2_odd_ok(shift_q, par_q);
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= PS2_BITCNT_INIT;
      shift_q  <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end
`endif

  assign rx.data       = data_q;
  assign rx.valid      = valid_q;
  assign rx.parity_err = perr_q;
  assign rx.frame_err  = ferr_q;
  assign rx.overrun    = ovr_q;
  assign rx.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Randomised bench for ps2_rx_frame against a frame-level model.
// Timeout cases run when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_rx_frame;
  localparam int FL = 8;
  localparam int TO = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;

  ps2_rx_frame_if rx ();

  ps2_rx_frame #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ps2c (ps2c),
    .ps2d (ps2d),
    .rx   (rx.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [8:0] got_q[$];
  int fe_cnt = 0;
  int fe_run = 0;
  int fe_maxw = 0;
  int exp_fe = 0;

  always @(negedge clk) begin
    if (rx.valid && rx.ready)
      got_q.push_back({rx.parity_err, rx.data});
    if (rx.frame_err) begin
      if (fe_run == 0) fe_cnt++;
      fe_run++;
      if (fe_run > fe_maxw) fe_maxw = fe_run;
    end else begin
      fe_run = 0;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic b);
    ps2d = b;
    wclk(10);
    ps2c = 1'b0;
    wclk(30);
    ps2c = 1'b1;
    wclk(20);
  endtask

  // Frame built from the protocol: start, LSB-first data, odd parity, stop
  task automatic send_frame(logic [7:0] d, bit par_bad, bit stop_bad);
    logic p;
    p = ~(^d);
    if (par_bad) p = ~p;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop_bad ? 1'b0 : 1'b1);
    ps2d = 1'b1;
    wclk(20);
  endtask

  task automatic send_partial(logic [7:0] d, int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    ps2d = 1'b1;
  endtask

  task automatic check_rx(string tag, logic [7:0] d, logic pe);
    logic [8:0] v;
    chk({tag, "_n"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      v = got_q.pop_front();
      chk({tag, "_data"}, v[7:0], d);
      chk({tag, "_perr"}, v[8], pe);
    end
    got_q.delete();
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_data"}, rx.data, 8'h00);
    chk({tag, "_valid"}, rx.valid, 0);
    chk({tag, "_perr"}, rx.parity_err, 0);
    chk({tag, "_ferr"}, rx.frame_err, 0);
    chk({tag, "_ovr"}, rx.overrun, 0);
    chk({tag, "_busy"}, rx.busy, 0);
  endtask

  initial begin
    logic [7:0] d;
    bit pb, sb;
    rx.ready = 1'b1;
    wclk(3);
    check_reset("rst");
    rst_n = 1'b1;
    wclk(5);

    send_frame(8'h1C, 0, 0);
    check_rx("b1c", 8'h1C, 0);

    send_frame(8'hF0, 1, 0);
    check_rx("bf0", 8'hF0, 1);

    send_frame(8'h55, 0, 1);
    exp_fe++;
    chk("b55_fe", fe_cnt, exp_fe);
    chk("b55_none", got_q.size(), 0);
    chk("b55_valid", rx.valid, 0);
    chk("b55_busy", rx.busy, 0);

    rx.ready = 1'b0;
    send_frame(8'h12, 0, 0);
    send_frame(8'h34, 0, 0);
    chk("ovr_data", rx.data, 8'h12);
    chk("ovr_valid", rx.valid, 1);
    chk("ovr_flag", rx.overrun, 1);
    rx.ready = 1'b1;
    wclk(1);
    rx.ready = 1'b0;
    wclk(2);
    chk("ovr_clr_valid", rx.valid, 0);
    chk("ovr_clr_flag", rx.overrun, 0);
    check_rx("ovr", 8'h12, 0);
    rx.ready = 1'b1;

    ps2d = 1'b0;
    for (int g = 0; g < 2; g++) begin
      ps2c = 1'b0;
      wclk(FL - 1);
      ps2c = 1'b1;
      wclk(20);
    end
    chk("glitch_busy", rx.busy, 0);
    ps2d = 1'b1;
    wclk(5);
    send_frame(8'hAA, 0, 0);
    check_rx("baa", 8'hAA, 0);

    for (int n = 0; n < 12; n++) begin
      d  = 8'($urandom);
      pb = ($urandom % 4) == 0;
      sb = ($urandom % 5) == 0;
      send_frame(d, pb, sb);
      if (sb) begin
        exp_fe++;
        chk("rnd_none", got_q.size(), 0);
      end else begin
        check_rx("rnd", d, pb);
      end
      chk("rnd_fe", fe_cnt, exp_fe);
    end

    send_frame(8'h77, 0, 0);
    check_rx("pre_rst", 8'h77, 0);
    send_partial(8'h5A, 4);
    chk("mid_busy", rx.busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    wclk(2);
    rst_n = 1'b1;
    wclk(5);
    chk("mid_fe", fe_cnt, exp_fe);

`ifdef PS2_RX_TIMEOUT_EN
    send_partial(8'h3C, 4);
    wclk(TO + 50);
    exp_fe++;
    chk("to_fe", fe_cnt, exp_fe);
    chk("to_busy", rx.busy, 0);
    send_frame(8'h1C, 0, 0);
    check_rx("to_next", 8'h1C, 0);
`endif

    chk("fe_width", fe_maxw, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
